dmem_uart_tx: RTL and testbench
===============================

Name: dmem_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus.
- Acts as the responder to the backend's load/store traffic: decodes word address, active-low strobes and byte enables, and returns read data.
- Written bytes are buffered in a TX FIFO and serialised 8N1 on txd.
- Provides console output for programs running on the homebrew core.

Parameters:
- DEPTH, 4, TX FIFO entries (power of two, >=2).
- DIV_RESET, 868, reset value of the baud divisor in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- cs_n  in  1  device select, active low.
- oe_n  in  1  read strobe, active low.
- we_n  in  1  write strobe, active low.
- be_n  in  4  byte-lane enables, active low; lane i = bits [8i+7:8i].
- addr  in  2  word address (bus address bits [3:2]).
- wdata  in  32  store data.
- rdata  out  32  load data.
- txd  out  1  serial output, idle high.
- irq_n  out  1  interrupt, active low.

Behaviour:
- Register map (word address):
  - 0 TXDATA: write lane 0 pushes wdata[7:0]; reads 0.
  - 1 STATUS (RO except bit3): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky, write-1-clear via lane 0), bits[7:4] = FIFO count.
  - 2 DIVISOR: bits[15:0], byte-writable per lane 0/1; upper lanes ignored.
  - 3 IE: bit0 = tx-idle interrupt enable.
- Write: commits at rising clk when cs_n=0, we_n=0, and the relevant be_n bit is 0. Lanes with be_n=1 leave the register unchanged.
- Read: combinational. rdata = selected register when cs_n=0, oe_n=0, we_n=1; otherwise 32'h0.
  - Unused bits read 0.
  - be_n does not gate reads; the backend selects lanes.
- cs_n=0 with both oe_n=0 and we_n=0: treated as a write; rdata=0.
- FIFO:
  - Circular buffer with read pointer, write pointer and count (0..DEPTH).
  - Push accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. When count>0, pop the head into the shift register and go to START (bit counter=0, baud counter=0).
  - START: txd=0 for one bit period, then DATA.
  - DATA: txd=shift[0], LSB first. At each bit end, shift right; after bit 7 go to STOP.
  - STOP: txd=1 for one bit period, then IDLE. A waiting byte is popped on the next cycle, giving one idle cycle between frames.
  - Bit period = DIVISOR clk cycles; DIVISOR=0 behaves as 1.
  - The baud counter counts 0..period-1. Bit end is when the counter equals period-1.
  - A DIVISOR write mid-frame takes effect at the next bit-end comparison.
- irq_n = ~(IE[0] & empty & ~busy), combinational from registered state.
- Reset (asynchronous, rst=1):
  - FIFO empty; pointers and count 0; overflow 0; DIVISOR=DIV_RESET; IE=0.
  - FSM IDLE; txd=1; irq_n=1; rdata follows the read rule with reset values (STATUS reads 32'h2).
  - Reset mid-frame aborts the frame immediately with txd=1; buffered bytes are discarded.

Test Plan:
- Reset, then read STATUS -> rdata=32'h00000002, txd=1, irq_n=1.
- DIVISOR=4, write TXDATA 8'hA5 -> txd waveform over 40 cycles:
  - 0 for 4 cycles;
  - bits 1,0,1,0,0,1,0,1 for 4 cycles each;
  - 1 for 4 cycles;
  - start bit begins 2 cycles after the write edge;
  - STATUS busy=1 during the frame.
- DIVISOR=1, write 6 bytes back-to-back while the FSM is busy with DEPTH=4 -> the first byte is popped immediately and 4 are buffered, so 5 are transmitted. The 6th is dropped and STATUS bit3=1. Writing STATUS lane 0 with 32'h8 clears bit3 -> read 32'h0 in bit3.
- Write DIVISOR with be_n=4'b1110, wdata=32'hFFFF_1234 -> DIVISOR reads 32'h0000_0334 (starting from 868=32'h364; only lane 0 updated).
- IE=1, send one byte -> irq_n=1 while busy; goes 0 the cycle after the STOP bit ends; then writing TXDATA drives irq_n=1 on the next edge.
- Assert rst during the DATA bit 3 of a frame with 2 bytes queued -> txd=1 asynchronously. After release: STATUS=32'h2, no further frames.

Source files
------------

// File: rtl/dmem_uart_tx.sv
// Memory-mapped UART transmitter: data-memory bus responder, byte TX FIFO, 8N1 serialiser.
module dmem_uart_tx #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIV_RESET = 868
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs_n,
    input  logic        i_oe_n,
    input  logic        i_we_n,
    input  logic [3:0]  i_be_n,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_txd,
    output logic        o_irq_n
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t         r_state, w_state_next;
    logic [7:0]     r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_ovf;
    logic [15:0]    r_div;
    logic           r_ie;
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_cnt;
    logic [15:0]    r_baud;
    logic           r_txd;

    logic           w_wr, w_rd, w_push, w_push_ok, w_pop;
    logic           w_full, w_empty, w_busy, w_bit_end, w_txd_next;
    logic [15:0]    w_period;
    logic           w_unused_bits;

    assign w_wr      = ~i_cs_n & ~i_we_n;
    assign w_rd      = ~i_cs_n & ~i_oe_n & i_we_n;
    assign w_push    = w_wr & (i_addr == 2'd0) & ~i_be_n[0];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != StIdle);
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_period  = (r_div == 16'd0) ? 16'd1 : r_div;
    // >= rather than == so a divisor shrunk mid-bit cannot strand the counter.
    assign w_bit_end = (r_baud >= (w_period - 16'd1));
    assign w_unused_bits = ^{i_wdata[31:16], i_be_n[3:2]};

    // FIFO storage write
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata[7:0];
        end
    end

    // FIFO pointers, count and sticky overflow flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_wr && i_addr == 2'd1 && !i_be_n[0] && i_wdata[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Divisor and interrupt-enable registers with per-lane write enables
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= 16'(DIV_RESET);
            r_ie  <= 1'b0;
        end else if (w_wr) begin
            if (i_addr == 2'd2 && !i_be_n[0]) r_div[7:0]  <= i_wdata[7:0];
            if (i_addr == 2'd2 && !i_be_n[1]) r_div[15:8] <= i_wdata[15:8];
            if (i_addr == 2'd3 && !i_be_n[0]) r_ie        <= i_wdata[0];
        end
    end

    // TX FSM state register and registered serial output
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_txd   <= w_txd_next;
        end
    end

    // TX FSM next state, pop request and line level
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_txd_next = 1'b0;
                if (w_bit_end) w_state_next = StData;
            end
            StData: begin
                w_txd_next = r_shift[0];
                if (w_bit_end && r_bit_cnt == 3'd7) w_state_next = StStop;
            end
            StStop: begin
                if (w_bit_end) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Shift register, bit counter and baud counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_baud    <= 16'd0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bit_cnt <= 3'd0;
            r_baud    <= 16'd0;
        end else if (w_busy) begin
            if (w_bit_end) begin
                r_baud <= 16'd0;
                if (r_state == StData) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    // Combinational read mux; zero unless a pure read is strobed
    always_comb begin
        o_rdata = 32'h0;
        if (w_rd) begin
            case (i_addr)
                2'd1:    o_rdata = {24'h0, 4'(r_count), r_ovf, w_busy, w_empty, w_full};
                2'd2:    o_rdata = {16'h0, r_div};
                2'd3:    o_rdata = {31'h0, r_ie};
                default: o_rdata = 32'h0;
            endcase
        end
    end

    assign o_txd   = r_txd;
    assign o_irq_n = ~(r_ie & w_empty & ~w_busy);

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Self-checking bench for dmem_uart_tx: directed scenarios plus randomized bus traffic
// against a frame-timeline reference model.
module tb_dmem_uart_tx;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned DIV_RESET = 868;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, oe_n, we_n;
    logic [3:0]  be_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd, irq_n;

    always #5 clk = ~clk;

    dmem_uart_tx #(.DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_cs_n  (cs_n),
        .i_oe_n  (oe_n),
        .i_we_n  (we_n),
        .i_be_n  (be_n),
        .i_addr  (addr),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_txd   (txd),
        .o_irq_n (irq_n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued bytes plus the elapsed time of the frame in flight.
    logic [7:0]  m_q[$];
    bit          m_busy;
    int          m_t;
    logic [7:0]  m_byte;
    logic        m_txd;
    logic        m_ovf;
    logic [15:0] m_div;
    logic        m_ie;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_t    = 0;
        m_byte = 8'h00;
        m_txd  = 1'b1;
        m_ovf  = 1'b0;
        m_div  = 16'(DIV_RESET);
        m_ie   = 1'b0;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s      = 32'h0;
        s[7:4] = 4'(m_q.size());
        s[3]   = m_ovf;
        s[2]   = m_busy;
        s[1]   = (m_q.size() == 0);
        s[0]   = (m_q.size() == DEPTH);
        return s;
    endfunction

    function automatic logic [31:0] model_rdata(input logic c, input logic o, input logic w,
                                                input logic [1:0] a);
        if (c || o || !w) return 32'h0;
        case (a)
            2'd1:    return model_status();
            2'd2:    return {16'h0, m_div};
            2'd3:    return {31'h0, m_ie};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq_n();
        return !(m_ie && m_q.size() == 0 && !m_busy);
    endfunction

    // Advance the model across one rising edge with the given bus inputs.
    task automatic model_step(input logic c, input logic w, input logic [3:0] b,
                              input logic [1:0] a, input logic [31:0] d);
        int   p;
        int   k;
        logic nt;
        bit   pop;
        bit   wr;
        p  = (m_div == 16'd0) ? 1 : int'(m_div);
        nt = 1'b1;
        if (m_busy) begin
            k = m_t / p;
            if (k == 0)      nt = 1'b0;
            else if (k <= 8) nt = m_byte[k-1];
        end
        pop = !m_busy && m_q.size() > 0;
        wr  = !c && !w;
        if (pop) m_byte = m_q.pop_front();
        if (wr && a == 2'd0 && !b[0]) begin
            if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
            else                    m_ovf = 1'b1;
        end
        if (m_busy) begin
            m_t++;
            if (m_t == 10 * p) m_busy = 1'b0;
        end
        if (pop) begin
            m_busy = 1'b1;
            m_t    = 0;
        end
        m_txd = nt;
        if (wr && a == 2'd1 && !b[0] && d[3]) m_ovf = 1'b0;
        if (wr && a == 2'd2) begin
            if (!b[0]) m_div[7:0]  = d[7:0];
            if (!b[1]) m_div[15:8] = d[15:8];
        end
        if (wr && a == 2'd3 && !b[0]) m_ie = d[0];
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic bus(input logic c, input logic o, input logic w, input logic [3:0] b,
                       input logic [1:0] a, input logic [31:0] d, input string tag,
                       output logic [31:0] rd_seen);
        cs_n = c; oe_n = o; we_n = w; be_n = b; addr = a; wdata = d;
        #1;
        rd_seen = rdata;
        check({tag, "/rdata"}, rdata, model_rdata(c, o, w, a));
        @(posedge clk);
        model_step(c, w, b, a, d);
        @(negedge clk);
        check({tag, "/txd"}, {31'h0, txd}, {31'h0, m_txd});
        check({tag, "/irq_n"}, {31'h0, irq_n}, {31'h0, model_irq_n()});
    endtask

    task automatic idle(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) bus(1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 32'h0, "idle", r);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b0, 1'b1, 1'b0, b, a, d, "write", r);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        bus(1'b0, 1'b0, 1'b1, 4'hF, a, 32'h0, "read", r);
    endtask

    task automatic rd_const(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        rd(a, r);
        check(tag, r, exp);
    endtask

    function automatic logic a5_wave(input int n);
        logic [7:0] v;
        int j;
        v = 8'hA5;
        if (n < 2) return 1'b1;
        j = (n - 2) / 4;
        if (j == 0) return 1'b0;
        if (j <= 8) return v[j-1];
        return 1'b1;
    endfunction

    initial begin
        logic [31:0] r;
        int          op;
        logic [3:0]  rb;
        logic [31:0] rw;
        logic        ro;
        int          guard;

        cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; be_n = 4'hF; addr = 2'd0; wdata = 32'h0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset/txd", {31'h0, txd}, 32'h1);
        check("reset/irq_n", {31'h0, irq_n}, 32'h1);
        rst = 1'b0;

        rd_const(2'd1, 32'h0000_0002, "reset/status");

        // Lane 0 only: 0x0364 -> 0x0334.
        wr(2'd2, 4'b1110, 32'hFFFF_1234);
        rd_const(2'd2, 32'h0000_0334, "div/lane0");

        // Frame 0xA5 at 4 clocks per bit, polled through STATUS reads.
        wr(2'd2, 4'b1100, 32'h0000_0004);
        wr(2'd0, 4'b1110, 32'h0000_00A5);
        for (int n = 1; n <= 44; n++) begin
            rd(2'd1, r);
            check("a5/wave", {31'h0, txd}, {31'h0, a5_wave(n)});
            if (n >= 2 && n <= 40) check("a5/busy", r & 32'h4, 32'h4);
        end

        // Overflow: six back-to-back bytes at 1 clock per bit.
        wr(2'd2, 4'b1100, 32'h0000_0001);
        for (int i = 0; i < 6; i++) wr(2'd0, 4'b1110, 32'h40 + i);
        rd_const(2'd1, 32'h0000_004D, "ovf/status");
        wr(2'd1, 4'b1110, 32'h0000_0008);
        rd(2'd1, r);
        check("ovf/clear", r & 32'h8, 32'h0);
        idle(80);

        // Idle interrupt.
        wr(2'd3, 4'b1110, 32'h1);
        check("ie/idle_irq", {31'h0, irq_n}, 32'h0);
        wr(2'd0, 4'b1110, 32'h5A);
        check("ie/busy_irq", {31'h0, irq_n}, 32'h1);
        idle(15);
        check("ie/done_irq", {31'h0, irq_n}, 32'h0);
        wr(2'd0, 4'b1110, 32'hC3);
        check("ie/write_irq", {31'h0, irq_n}, 32'h1);
        idle(20);

        // Randomized traffic; divisor only changes between frames.
        for (int i = 0; i < 500; i++) begin
            op = $urandom_range(0, 9);
            rb = 4'($urandom);
            rw = $urandom;
            ro = 1'($urandom);
            case (op)
                0, 1:    idle(1);
                2, 3:    rd(2'($urandom), r);
                4, 5, 6: bus(1'b0, ro, 1'b0, rb, 2'd0, rw, "rnd_tx", r);
                7:       bus(1'b0, ro, 1'b0, rb, 2'd1, rw, "rnd_st", r);
                8:       bus(1'b0, ro, 1'b0, rb, 2'd3, rw, "rnd_ie", r);
                default: begin
                    if (!m_busy && m_q.size() == 0)
                        bus(1'b0, ro, 1'b0, rb, 2'd2, {rw[31:16], 14'h0, rw[1:0]}, "rnd_div", r);
                    else
                        bus(1'b1, ro, 1'b0, rb, 2'd2, rw, "rnd_nocs", r);
                end
            endcase
        end
        idle(150);

        // Reset during data bit 3 with two bytes queued.
        wr(2'd2, 4'b1100, 32'h4);
        wr(2'd0, 4'b1110, 32'hA5);
        wr(2'd0, 4'b1110, 32'h11);
        wr(2'd0, 4'b1110, 32'h22);
        guard = 0;
        while (!(m_busy && m_t / 4 == 4 && m_t % 4 == 2) && guard < 100) begin
            idle(1);
            guard++;
        end
        check("rst/reached_bit3", guard < 100 ? 32'h1 : 32'h0, 32'h1);
        check("rst/pre_txd", {31'h0, txd}, 32'h0);
        rst = 1'b1;
        #1;
        check("rst/async_txd", {31'h0, txd}, 32'h1);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_const(2'd1, 32'h0000_0002, "rst/status");
        idle(60);
        check("rst/no_frames", {31'h0, txd}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
